de_selector_seq: RTL and testbench
==================================

Name: de_selector_seq

Overview:
- Parametrised, registered 1-to-N demultiplexer: the successor to the 1-to-4 combinational distributor.
- Routes DATA_W-bit input iC to one of CHANNELS output lanes; every unselected lane drives the idle level.
- Adds registered outputs, an auto-scan mode with a wrap-around channel counter, and a hold/freeze control.
- Sits between a single data source and N downstream consumers, e.g. LED/segment drivers or time-multiplexed channels.

Parameters:
- CHANNELS, 4: number of output lanes, 2..16.
- DATA_W, 1: width of iC and of each output lane.
- SEL_W, $clog2(CHANNELS): width of the select and current-channel ports.
- IDLE_LVL, 1'b1: bit value replicated across every unselected lane, and across all lanes after reset.

Ports:
- iClk  input  1  system clock, rising edge.
- iRst  input  1  asynchronous reset, active-high.
- iC  input  DATA_W  data to distribute.
- iSel  input  SEL_W  channel select, used in direct mode.
- iMode  input  1  0 = direct select, 1 = auto scan.
- iStep  input  1  scan advance strobe, one channel per cycle high.
- iHold  input  1  freeze: outputs and counter keep their values.
- oZ  output  CHANNELS*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- oSelCur  output  SEL_W  channel currently driven.
- oWrap  output  1  one-cycle pulse when the scan counter wraps.
- oValid  output  1  high when oSelCur < CHANNELS and the block is not in hold.

Behaviour:
- Reset (async assert, sync release):
  - oZ = all lanes IDLE_LVL.
  - oSelCur = 0, oWrap = 0, oValid = 0.
  - State = S_DIRECT.
- FSM states: S_DIRECT, S_SCAN, S_HOLD.
  - Any state, iHold=1 → S_HOLD; all outputs keep their values; oWrap = 0; oValid = 0.
  - S_HOLD, iHold=0 → S_DIRECT if iMode=0, else S_SCAN; the counter resumes from its held value.
  - S_DIRECT ↔ S_SCAN follows iMode, with a one-cycle transition.
  - On entry to S_SCAN the counter starts from the current oSelCur, with no jump.
- S_DIRECT:
  - sel_q <= iSel every cycle.
  - If iSel >= CHANNELS (non-power-of-2 CHANNELS), all lanes = IDLE_LVL and oValid = 0.
- S_SCAN:
  - On iStep=1: sel_q <= (sel_q == CHANNELS-1) ? 0 : sel_q + 1.
  - A wrap sets oWrap = 1 for exactly one cycle, aligned with oSelCur = 0.
  - On iStep=0 the counter holds.
- Latency: one clock.
  - Lane sel_q drives the iC sampled on the same edge that updates sel_q.
  - oZ, oSelCur, oValid and oWrap are all registered and mutually consistent in every cycle.
- Simultaneous events, in priority order: iRst > iHold > mode change > iStep.
  - An iStep in the cycle where iMode rises is ignored.
- Reset mid-scan: all outputs return to reset values immediately (async); the counter restarts at 0.
- Only one lane ever carries iC; glitch-free since all outputs are flops.

Decomposition:
- Package de_pkg holds:
  - the state encoding (S_DIRECT = 2'd0, S_SCAN = 2'd1, S_HOLD = 2'd2);
  - the MODE_DIRECT / MODE_SCAN constants;
  - a function replicating IDLE_LVL to a lane width.
- One natural sub-module: de_scan_counter.
  - Parametrised modulo-CHANNELS counter with load, enable and wrap-pulse outputs.
  - Instantiated once, holding sel_q.
- Lane decode and output registers live in the top level.

Test Plan:
1. Reset with CHANNELS=4, DATA_W=1. Assert iRst mid-cycle → oZ = 4'b1111, oSelCur = 0, oValid = 0, asynchronously, with no clock edge needed.
2. Direct mode, iC=0, iSel stepped 0..3 → one cycle later oZ = 1110, 1101, 1011, 0111 respectively; oValid = 1.
3. CHANNELS=3: iSel=3 → oZ = 3'b111, oValid = 0. Then iSel=2 with iC=0 → oZ = 3'b011.
4. Scan mode, iStep held high for 5 cycles from sel 0 → oSelCur = 1, 2, 3, 0, 1; oWrap high only in the cycle oSelCur returns to 0.
5. iHold=1 at oSelCur=2 while iStep toggles for 4 cycles → oSelCur stays 2, oZ frozen, oValid = 0. After release the count resumes at 3.
6. DATA_W=8, CHANNELS=4, IDLE_LVL=0, direct mode, iSel=1, iC=8'hA5 → oZ = 32'h0000_A500.

Source files
------------

// File: rtl/de_pkg.sv
// Shared types and helpers for the registered 1-to-N de-selector.
package de_pkg;

  // Controller states; HOLD freezes everything until released.
  typedef enum logic [1:0] {
    S_DIRECT = 2'd0,
    S_SCAN   = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  // Values carried by the mode input.
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Replicates a single idle bit across the low 'width' bits; callers cast to their lane width.
  function automatic logic [63:0] fill_lane(input logic lvl, input int width);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) r[i] = lvl;
    end
    return r;
  endfunction

endpackage

// File: rtl/de_scan_counter.sv
// Modulo-CHANNELS channel counter with load, enable and a registered wrap pulse.
// count_nxt exposes the value the counter will take on the next edge so the
// lane decoder can register data for the same channel in the same cycle.
module de_scan_counter #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  input  logic             en,
  output logic [SEL_W-1:0] count,
  output logic [SEL_W-1:0] count_nxt,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  logic at_last;

  // An out-of-range value (loaded in direct mode) is treated like the last channel so a step returns to 0.
  assign at_last = (count >= LAST);

  // Next count: load wins over enable, otherwise hold.
  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = load_val;
    end else if (en) begin
      count_nxt = at_last ? '0 : count + SEL_W'(1);
    end
  end

  // Counter register and one-cycle wrap pulse aligned with the return to channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= !load && en && at_last;
    end
  end

endmodule

// File: rtl/de_selector_seq.sv
// Registered 1-to-N demultiplexer with direct select, auto-scan and hold.
// The selected lane carries iC, every other lane sits at the idle level.
module de_selector_seq
  import de_pkg::*;
#(
  parameter int   CHANNELS = 4,
  parameter int   DATA_W   = 1,
  parameter int   SEL_W    = $clog2(CHANNELS),
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic [DATA_W-1:0]          iC,
  input  logic [SEL_W-1:0]           iSel,
  input  logic                       iMode,
  input  logic                       iStep,
  input  logic                       iHold,
  output logic [CHANNELS*DATA_W-1:0] oZ,
  output logic [SEL_W-1:0]           oSelCur,
  output logic                       oWrap,
  output logic                       oValid
);

  localparam logic [DATA_W-1:0] IDLE_LANE = DATA_W'(fill_lane(IDLE_LVL, DATA_W));
  localparam logic [SEL_W:0]    CH_EXT    = (SEL_W + 1)'(CHANNELS);

  state_t                     state;
  state_t                     next_state;
  logic                       cnt_load;
  logic                       cnt_en;
  logic [SEL_W-1:0]           sel_q;
  logic [SEL_W-1:0]           sel_nxt;
  logic                       wrap;
  logic                       in_range;
  logic [CHANNELS*DATA_W-1:0] lanes_nxt;

  de_scan_counter #(
    .CHANNELS(CHANNELS),
    .SEL_W   (SEL_W)
  ) u_counter (
    .clk      (iClk),
    .rst      (iRst),
    .load     (cnt_load),
    .load_val (iSel),
    .en       (cnt_en),
    .count    (sel_q),
    .count_nxt(sel_nxt),
    .wrap     (wrap)
  );

  assign oSelCur = sel_q;
  assign oWrap   = wrap;

  // Next state and counter control: hold beats a mode change, a mode change beats a step.
  // Mode changes and leaving hold take one cycle during which the channel does not move.
  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    if (iHold) begin
      next_state = S_HOLD;
    end else begin
      case (state)
        S_HOLD: begin
          next_state = (iMode == MODE_SCAN) ? S_SCAN : S_DIRECT;
        end
        S_DIRECT: begin
          if (iMode == MODE_SCAN) next_state = S_SCAN;
          else                    cnt_load   = 1'b1;
        end
        S_SCAN: begin
          if (iMode == MODE_DIRECT) next_state = S_DIRECT;
          else                      cnt_en     = iStep;
        end
        default: next_state = S_DIRECT;
      endcase
    end
  end

  // Lane decode against the channel the counter is about to hold; out-of-range selects leave all lanes idle.
  always_comb begin
    lanes_nxt = {CHANNELS{IDLE_LANE}};
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_nxt == SEL_W'(k)) lanes_nxt[k*DATA_W +: DATA_W] = iC;
    end
    in_range = ({1'b0, sel_nxt} < CH_EXT);
  end

  // State and output registers; in hold the lanes freeze and valid drops.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state  <= S_DIRECT;
      oZ     <= {CHANNELS{IDLE_LANE}};
      oValid <= 1'b0;
    end else begin
      state <= next_state;
      if (iHold) begin
        oValid <= 1'b0;
      end else begin
        oZ     <= lanes_nxt;
        oValid <= in_range;
      end
    end
  end

endmodule

// File: tb/tb_de_selector_seq.sv
// Scoreboard bench for de_selector_seq: two configurations share one stimulus stream,
// a behavioural model queues the expected outputs and a monitor compares them each cycle.
module tb_de_selector_seq;

  typedef struct {
    int          sel;
    bit          scanning;
    bit          holding;
    logic [31:0] z;
  } mdl_t;

  typedef struct {
    logic [31:0] z;
    int          sel;
    bit          wrap;
    bit          valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ic = '0;
  logic [1:0]  sel = '0;
  logic        mode = 1'b0;
  logic        step = 1'b0;
  logic        hold = 1'b0;

  logic [3:0]  za;
  logic [1:0]  sel_a;
  logic        wrap_a;
  logic        valid_a;
  logic [23:0] zb;
  logic [1:0]  sel_b;
  logic        wrap_b;
  logic        valid_b;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  mdl_t m_a;
  mdl_t m_b;
  exp_t ea;
  exp_t eb;
  logic cur_mode = 1'b0;

  always #5 clk = ~clk;

  de_selector_seq #(.CHANNELS(4), .DATA_W(1), .IDLE_LVL(1'b1)) dut_a (
    .iClk(clk), .iRst(rst), .iC(ic[0:0]), .iSel(sel), .iMode(mode), .iStep(step),
    .iHold(hold), .oZ(za), .oSelCur(sel_a), .oWrap(wrap_a), .oValid(valid_a)
  );

  de_selector_seq #(.CHANNELS(3), .DATA_W(8), .IDLE_LVL(1'b0)) dut_b (
    .iClk(clk), .iRst(rst), .iC(ic), .iSel(sel), .iMode(mode), .iStep(step),
    .iHold(hold), .oZ(zb), .oSelCur(sel_b), .oWrap(wrap_b), .oValid(valid_b)
  );

  function automatic mdl_t model_reset(input int ch, input int w, input bit idle);
    mdl_t m;
    m.sel = 0;
    m.scanning = 1'b0;
    m.holding = 1'b0;
    m.z = '0;
    for (int b = 0; b < ch * w; b++) m.z[b] = idle;
    return m;
  endfunction

  // One clock of the behaviour: hold freezes, leaving hold or switching mode costs a cycle,
  // direct mode follows sel, scan mode advances modulo ch on step.
  function automatic void model_step(input mdl_t m_in, input int ch, input int w, input bit idle,
                                     output mdl_t m, output exp_t e);
    m = m_in;
    e.wrap = 1'b0;
    e.valid = 1'b0;
    if (hold) begin
      m.holding = 1'b1;
    end else begin
      if (m.holding || (m.scanning != mode)) begin
        m.holding = 1'b0;
        m.scanning = mode;
      end else if (!mode) begin
        m.sel = int'(sel);
      end else if (step) begin
        if (m.sel >= ch - 1) begin
          m.sel = 0;
          e.wrap = 1'b1;
        end else begin
          m.sel = m.sel + 1;
        end
      end
      e.valid = (m.sel < ch);
      m.z = '0;
      for (int k = 0; k < ch; k++)
        for (int b = 0; b < w; b++)
          m.z[k*w + b] = (k == m.sel) ? ic[b] : idle;
    end
    e.z = m.z;
    e.sel = m.sel;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
  endtask

  task automatic applyStimulus(input logic [7:0] c, input logic [1:0] s, input logic md,
                               input logic st, input logic hd);
    @(negedge clk);
    ic = c;
    sel = s;
    mode = md;
    step = st;
    hold = hd;
  endtask

  // Asserts reset away from any clock edge and checks the outputs clear immediately.
  task automatic pulseReset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_a_z", {28'd0, za}, 32'h0000000F);
    checkOutput("rst_a_sel", {30'd0, sel_a}, 32'd0);
    checkOutput("rst_a_valid", {31'd0, valid_a}, 32'd0);
    checkOutput("rst_a_wrap", {31'd0, wrap_a}, 32'd0);
    checkOutput("rst_b_z", {8'd0, zb}, 32'd0);
    checkOutput("rst_b_sel", {30'd0, sel_b}, 32'd0);
    checkOutput("rst_b_valid", {31'd0, valid_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: one step per rising edge, expected results queued for the monitor.
  always @(posedge clk or posedge rst) begin
    mdl_t nm;
    exp_t e;
    if (rst) begin
      m_a = model_reset(4, 1, 1'b1);
      m_b = model_reset(3, 8, 1'b0);
      q_a.delete();
      q_b.delete();
    end else begin
      model_step(m_a, 4, 1, 1'b1, nm, e);
      m_a = nm;
      q_a.push_back(e);
      model_step(m_b, 3, 8, 1'b0, nm, e);
      m_b = nm;
      q_b.push_back(e);
    end
  end

  // Monitor: compares the registered outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && q_a.size() > 0 && q_b.size() > 0) begin
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      checkOutput("a_z", {28'd0, za}, ea.z);
      checkOutput("a_sel", {30'd0, sel_a}, 32'(ea.sel));
      checkOutput("a_wrap", {31'd0, wrap_a}, {31'd0, ea.wrap});
      checkOutput("a_valid", {31'd0, valid_a}, {31'd0, ea.valid});
      checkOutput("b_z", {8'd0, zb}, eb.z);
      checkOutput("b_sel", {30'd0, sel_b}, 32'(eb.sel));
      checkOutput("b_wrap", {31'd0, wrap_b}, {31'd0, eb.wrap});
      checkOutput("b_valid", {31'd0, valid_b}, {31'd0, eb.valid});
    end
  end

  initial begin
    $display("[TB] start");
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Direct select walk with zero data, including the out-of-range select for 3 lanes.
    for (int s = 0; s < 4; s++) applyStimulus(8'h00, 2'(s), 1'b0, 1'b0, 1'b0);
    // Wide-lane routing of a known byte.
    applyStimulus(8'hA5, 2'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h3C, 2'd0, 1'b0, 1'b0, 1'b0);
    // Enter scan (step ignored on the mode change) then step through a wrap.
    for (int i = 0; i < 6; i++) applyStimulus(8'(i * 37), 2'd3, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h11, 2'd0, 1'b1, 1'b1, 1'b0);
    // Hold with toggling step, then release and resume.
    for (int i = 0; i < 4; i++) applyStimulus(8'hFF, 2'd0, 1'b1, 1'(i), 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(8'h5A, 2'd0, 1'b1, 1'b1, 1'b0);
    // Back to direct mode, then an asynchronous reset mid-operation.
    applyStimulus(8'h81, 2'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h81, 2'd2, 1'b0, 1'b0, 1'b0);
    pulseReset();

    // Randomised traffic with occasional mode flips, holds and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) pulseReset();
      if ($urandom_range(7) == 0) cur_mode = ~cur_mode;
      applyStimulus(8'($urandom), 2'($urandom), cur_mode, 1'($urandom),
                    1'($urandom_range(7) == 0));
    end

    applyStimulus(8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("queue_drained", 32'(q_a.size() + q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
